gmsk_modulator: RTL and testbench

// - Symbol-rate to sample-rate GMSK modulator that sits directly upstream of tx_burst.
// - Consumes one symbol per symbol interval on current_symbol and raises next_symbol_strobe to request the next one.
// - Paced by sample_strobe from tx_burst; returns one constant-envelope I/Q pair per strobe on modulator_inphase/quadrature.
// - Uses a precomputed Gaussian phase-trajectory ROM, combined with quadrant rotation.

---
 rtl/gmsk_modulator_pkg.sv | 68 ++++++
 rtl/gmsk_rom.sv | 25 ++
 rtl/gmsk_modulator.sv | 144 ++++++++++++++
 tb/tb_gmsk_modulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gmsk_modulator_pkg.sv
// Shared constants, quadrant type and the Gaussian phase-trajectory table (BT=0.3,
// three-symbol window, four samples per symbol) for the GMSK modulator and tx_burst.
package gmsk_modulator_pkg;

   localparam int SAMPLES_PER_SYMBOL = 4;
   localparam int ROM_OUTPUT_BITS    = 7;
   localparam int HISTORY            = 3;
   localparam int SIDX_BITS          = $clog2(SAMPLES_PER_SYMBOL);
   localparam int ROM_ADDR_BITS      = HISTORY + SIDX_BITS;
   localparam int IQ_BITS            = ROM_OUTPUT_BITS + 1;
   localparam int ROM_WIDTH          = 2 * IQ_BITS;

   typedef enum logic [1:0] {
      QUAD_0   = 2'd0,
      QUAD_90  = 2'd1,
      QUAD_180 = 2'd2,
      QUAD_270 = 2'd3
   } quadrant_e;

   function automatic logic [ROM_WIDTH-1:0] iq_pack(input logic signed [IQ_BITS-1:0] c,
                                                   input logic signed [IQ_BITS-1:0] s);
      return {c, s};
   endfunction

   // Address is {oldest, centre, newest symbol, sidx}; entries are (cos, sin) of the
   // phase offset from the quadrant base, scaled to 127 and never -128.
   function automatic logic [ROM_WIDTH-1:0] rom_entry(input logic [ROM_ADDR_BITS-1:0] addr);
      logic [ROM_WIDTH-1:0] word;
      word = {ROM_WIDTH{1'b0}};
      case (addr)
         5'd0:    word = iq_pack( 8'sd127,  8'sd0  );
         5'd1:    word = iq_pack( 8'sd117, -8'sd48 );
         5'd2:    word = iq_pack( 8'sd90,  -8'sd90 );
         5'd3:    word = iq_pack( 8'sd48,  -8'sd117);
         5'd4:    word = iq_pack( 8'sd127,  8'sd0  );
         5'd5:    word = iq_pack( 8'sd118, -8'sd46 );
         5'd6:    word = iq_pack( 8'sd97,  -8'sd82 );
         5'd7:    word = iq_pack( 8'sd75,  -8'sd102);
         5'd8:    word = iq_pack( 8'sd109,  8'sd66 );
         5'd9:    word = iq_pack( 8'sd104,  8'sd73 );
         5'd10:   word = iq_pack( 8'sd90,   8'sd90 );
         5'd11:   word = iq_pack( 8'sd73,   8'sd104);
         5'd12:   word = iq_pack( 8'sd109,  8'sd66 );
         5'd13:   word = iq_pack( 8'sd102,  8'sd75 );
         5'd14:   word = iq_pack( 8'sd82,   8'sd97 );
         5'd15:   word = iq_pack( 8'sd46,   8'sd118);
         5'd16:   word = iq_pack( 8'sd109, -8'sd66 );
         5'd17:   word = iq_pack( 8'sd102, -8'sd75 );
         5'd18:   word = iq_pack( 8'sd82,  -8'sd97 );
         5'd19:   word = iq_pack( 8'sd46,  -8'sd118);
         5'd20:   word = iq_pack( 8'sd109, -8'sd66 );
         5'd21:   word = iq_pack( 8'sd104, -8'sd73 );
         5'd22:   word = iq_pack( 8'sd90,  -8'sd90 );
         5'd23:   word = iq_pack( 8'sd73,  -8'sd104);
         5'd24:   word = iq_pack( 8'sd127,  8'sd0  );
         5'd25:   word = iq_pack( 8'sd118,  8'sd46 );
         5'd26:   word = iq_pack( 8'sd97,   8'sd82 );
         5'd27:   word = iq_pack( 8'sd75,   8'sd102);
         5'd28:   word = iq_pack( 8'sd127,  8'sd0  );
         5'd29:   word = iq_pack( 8'sd117,  8'sd48 );
         5'd30:   word = iq_pack( 8'sd90,   8'sd90 );
         5'd31:   word = iq_pack( 8'sd48,   8'sd117);
         default: word = {ROM_WIDTH{1'b0}};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/gmsk_rom.sv
// Synchronous-read phase-trajectory ROM: one registered (cos, sin) word per enabled read.
module gmsk_rom
   import gmsk_modulator_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [ROM_ADDR_BITS-1:0] address,
   output logic [ROM_WIDTH-1:0]     data
);

   logic [ROM_WIDTH-1:0] data_r;

   // Registered read; the word holds until the next enabled read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= {ROM_WIDTH{1'b0}};
      end else if (enable) begin
         data_r <= rom_entry(address);
      end
   end

   assign data = data_r;

endmodule

// File: rtl/gmsk_modulator.sv
// GMSK modulator: symbol window and quadrant tracking, three-stage pipeline
// (address register, ROM read, quadrant rotation) producing one I/Q pair per sample_strobe.
module gmsk_modulator
   import gmsk_modulator_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         sample_strobe,
   input  logic         current_symbol,
   output logic         next_symbol_strobe,
   output logic [7:0]   modulator_inphase,
   output logic [7:0]   modulator_quadrature
);

   logic [SIDX_BITS-1:0]     sidx_r;
   logic [HISTORY-1:0]       history_r;
   quadrant_e                q_r;
   logic                     next_symbol_strobe_r;
   logic                     boundary_s;
   logic [1:0]               q_step_s;
   quadrant_e                q_next_s;

   logic                     v1_r;
   logic [ROM_ADDR_BITS-1:0] addr_r;
   quadrant_e                q1_r;
   logic                     v2_r;
   quadrant_e                q2_r;
   logic [ROM_WIDTH-1:0]     rom_data_s;

   logic signed [IQ_BITS-1:0] c_s;
   logic signed [IQ_BITS-1:0] s_s;
   logic signed [IQ_BITS-1:0] rot_i_s;
   logic signed [IQ_BITS-1:0] rot_q_s;
   logic [IQ_BITS-1:0]        inphase_r;
   logic [IQ_BITS-1:0]        quadrature_r;

   assign boundary_s = sample_strobe & (sidx_r == {SIDX_BITS{1'b1}});

   // Quadrant advance by the centre symbol of the window before it shifts.
   always_comb begin
      q_step_s = 2'd3;
      if (history_r[HISTORY/2]) begin
         q_step_s = 2'd1;
      end else begin
         q_step_s = 2'd3;
      end
      q_next_s = quadrant_e'(q_r + q_step_s);
   end

   // Sample index, symbol window, quadrant and the next-symbol request pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sidx_r               <= {SIDX_BITS{1'b0}};
         history_r            <= {HISTORY{1'b1}};
         q_r                  <= QUAD_0;
         next_symbol_strobe_r <= 1'b0;
      end else begin
         next_symbol_strobe_r <= boundary_s;
         if (sample_strobe) begin
            sidx_r <= sidx_r + SIDX_BITS'(1);
         end
         if (boundary_s) begin
            history_r <= {history_r[HISTORY-2:0], current_symbol};
            q_r       <= q_next_s;
         end
      end
   end

   // Stages 1 and 2 bookkeeping: pre-update address and quadrant travel with the sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         v1_r   <= 1'b0;
         addr_r <= {ROM_ADDR_BITS{1'b0}};
         q1_r   <= QUAD_0;
         v2_r   <= 1'b0;
         q2_r   <= QUAD_0;
      end else begin
         v1_r <= sample_strobe;
         v2_r <= v1_r;
         if (sample_strobe) begin
            addr_r <= {history_r, sidx_r};
            q1_r   <= q_r;
         end
         if (v1_r) begin
            q2_r <= q1_r;
         end
      end
   end

   gmsk_rom u_rom (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (v1_r),
      .address (addr_r),
      .data    (rom_data_s)
   );

   assign c_s = rom_data_s[ROM_WIDTH-1:IQ_BITS];
   assign s_s = rom_data_s[IQ_BITS-1:0];

   // Rotate the table offset onto the current quadrant; the table never holds -128.
   always_comb begin
      rot_i_s = c_s;
      rot_q_s = s_s;
      case (q2_r)
         QUAD_0: begin
            rot_i_s = c_s;
            rot_q_s = s_s;
         end
         QUAD_90: begin
            rot_i_s = -s_s;
            rot_q_s = c_s;
         end
         QUAD_180: begin
            rot_i_s = -c_s;
            rot_q_s = -s_s;
         end
         QUAD_270: begin
            rot_i_s = s_s;
            rot_q_s = -c_s;
         end
         default: begin
            rot_i_s = c_s;
            rot_q_s = s_s;
         end
      endcase
   end

   // Stage 3 output register; holds between samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inphase_r    <= {IQ_BITS{1'b0}};
         quadrature_r <= {IQ_BITS{1'b0}};
      end else if (v2_r) begin
         inphase_r    <= rot_i_s;
         quadrature_r <= rot_q_s;
      end
   end

   assign next_symbol_strobe   = next_symbol_strobe_r;
   assign modulator_inphase    = inphase_r;
   assign modulator_quadrature = quadrature_r;

endmodule

// File: tb/tb_gmsk_modulator.sv
// Scoreboard bench for gmsk_modulator: the driver pushes hand-tabulated I/Q expectations,
// a monitor pops them three clocks after each strobe and checks hold, strobe and envelope.
module tb_gmsk_modulator;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_strobe = 1'b0;
   logic       current_symbol = 1'b0;
   logic       next_symbol_strobe;
   logic [7:0] modulator_inphase;
   logic [7:0] modulator_quadrature;

   gmsk_modulator dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .sample_strobe        (sample_strobe),
      .current_symbol       (current_symbol),
      .next_symbol_strobe   (next_symbol_strobe),
      .modulator_inphase    (modulator_inphase),
      .modulator_quadrature (modulator_quadrature)
   );

   always #5 clock = ~clock;

   // Hand-computed Gaussian (BT=0.3) phase offsets, index {oldest, centre, newest, sidx}.
   localparam logic signed [7:0] ROM_C [32] = '{
      8'sd127, 8'sd117, 8'sd90, 8'sd48,  8'sd127, 8'sd118, 8'sd97, 8'sd75,
      8'sd109, 8'sd104, 8'sd90, 8'sd73,  8'sd109, 8'sd102, 8'sd82, 8'sd46,
      8'sd109, 8'sd102, 8'sd82, 8'sd46,  8'sd109, 8'sd104, 8'sd90, 8'sd73,
      8'sd127, 8'sd118, 8'sd97, 8'sd75,  8'sd127, 8'sd117, 8'sd90, 8'sd48};
   localparam logic signed [7:0] ROM_S [32] = '{
      8'sd0, -8'sd48, -8'sd90, -8'sd117,  8'sd0, -8'sd46, -8'sd82, -8'sd102,
      8'sd66, 8'sd73, 8'sd90, 8'sd104,    8'sd66, 8'sd75, 8'sd97, 8'sd118,
      -8'sd66, -8'sd75, -8'sd97, -8'sd118, -8'sd66, -8'sd73, -8'sd90, -8'sd104,
      8'sd0, 8'sd46, 8'sd82, 8'sd102,     8'sd0, 8'sd48, 8'sd90, 8'sd117};

   typedef struct {
      int i;
      int q;
   } iq_t;

   iq_t        exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         m_sidx;
   int         m_q;
   logic [2:0] m_hist;
   logic       junk = 1'b0;
   logic       drv_boundary = 1'b0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_sidx = 0;
      m_q    = 0;
      m_hist = 3'b111;
   endtask

   task automatic strobe_once(input logic sym);
      int  a;
      int  c;
      int  s;
      iq_t e;
      @(negedge clock);
      drv_boundary   = (m_sidx == 3);
      current_symbol = drv_boundary ? sym : junk;
      junk           = ~junk;
      sample_strobe  = 1'b1;
      a = int'(m_hist) * 4 + m_sidx;
      c = ROM_C[a];
      s = ROM_S[a];
      case (m_q)
         0:       begin e.i = c;  e.q = s;  end
         1:       begin e.i = -s; e.q = c;  end
         2:       begin e.i = -c; e.q = -s; end
         default: begin e.i = s;  e.q = -c; end
      endcase
      exp_q.push_back(e);
      if (drv_boundary) begin
         m_q    = (m_q + (m_hist[1] ? 1 : 3)) % 4;
         m_hist = {m_hist[1:0], sym};
      end
      m_sidx = (m_sidx + 1) % 4;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         sample_strobe  = 1'b0;
         drv_boundary   = 1'b0;
         current_symbol = junk;
         junk           = ~junk;
      end
   endtask

   task automatic send_symbol(input logic sym, input int gap);
      repeat (4) begin
         strobe_once(sym);
         if (gap > 0) idle(gap);
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clock);
      reset_n       = 1'b0;
      sample_strobe = 1'b0;
      drv_boundary  = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("reset_i_immediate", int'($signed(modulator_inphase)), 0);
      check("reset_q_immediate", int'($signed(modulator_quadrature)), 0);
      check("reset_nss_immediate", int'(next_symbol_strobe), 0);
      idle(n);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Monitor: strobes seen at a posedge are due on the output after the third posedge.
   initial begin
      logic [2:0] pend;
      logic       s_cap;
      logic       b_cap;
      int         last_i;
      int         last_q;
      int         ii;
      int         qq;
      iq_t        e;
      pend   = 3'b000;
      last_i = 0;
      last_q = 0;
      forever begin
         @(posedge clock);
         s_cap = sample_strobe & reset_n;
         b_cap = drv_boundary & sample_strobe & reset_n;
         #2;
         ii = int'($signed(modulator_inphase));
         qq = int'($signed(modulator_quadrature));
         if (!reset_n) begin
            pend   = 3'b000;
            last_i = 0;
            last_q = 0;
         end else begin
            pend = {pend[1:0], s_cap};
         end
         if (pend[2]) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sample_i", ii, e.i);
               check("sample_q", qq, e.q);
               vectors++;
               if ((ii * ii + qq * qq) < 15645 || (ii * ii + qq * qq) > 16613) begin
                  miscompares++;
                  $display("FAIL envelope: actual %0d required 15645..16613", ii * ii + qq * qq);
               end
               last_i = e.i;
               last_q = e.q;
            end
         end else begin
            check("hold_i", ii, last_i);
            check("hold_q", qq, last_q);
         end
         check("next_symbol_strobe", int'(next_symbol_strobe), int'(b_cap));
      end
   end

   initial begin
      logic [31:0] pat;
      pat = 32'hB38F_4C1D;
      model_reset();
      // Strobes toggling while held in reset must be ignored.
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         sample_strobe = (i % 2 == 1);
      end
      @(negedge clock);
      sample_strobe = 1'b0;
      reset_n       = 1'b1;
      // Single strobe latency, then cadence with continuous ones.
      strobe_once(1'b1);
      idle(8);
      for (int k = 0; k < 5; k++) send_symbol(1'b1, 3);
      for (int k = 0; k < 5; k++) send_symbol(1'b0, 1);
      for (int k = 0; k < 6; k++) send_symbol(k % 2 == 0, 0);
      // Mid-symbol reset discards the partial symbol.
      strobe_once(1'b1);
      strobe_once(1'b0);
      apply_reset(3);
      for (int k = 0; k < 64; k++) send_symbol(pat[k % 32], k % 3);
      idle(6);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
